// File: rtl/fa_share_arb.sv
// Round-robin arbiter sharing a single W-bit full-adder datapath among NREQ requesters.
// The granted sum is registered with the winner's ID and held under a valid/ready handshake.
module fa_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 5,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ-1:0]   cin_in,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [W-1:0]      res_s,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready
);

    localparam int unsigned N = NREQ;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] last_q;
    logic           res_valid_q;
    logic [W-1:0]   res_s_q;
    logic           res_cout_q;
    logic [IDW-1:0] res_id_q;

    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    logic           accept;
    int unsigned    idx;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           cin_sel;
    logic [W:0]     sum_d;

    // Scan last+1, last+2, ... with wrap; the first active request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx  = (32'(last_q) + k) % N;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Reset gating keeps gnt low even if requests are present during reset.
    assign accept = rst_n && found && (state_q == IDLE || res_ready);
    assign gnt    = accept ? (NREQ'(1) << win) : '0;

    // Only the winner's operands reach the adder, so idle lanes never leak into results.
    assign a_sel   = a_in[win*W +: W];
    assign b_sel   = b_in[win*W +: W];
    assign cin_sel = cin_in[win];
    assign sum_d   = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
        end else if (accept) begin
            state_q                 <= HOLD;
            last_q                  <= win;
            res_valid_q             <= 1'b1;
            {res_cout_q, res_s_q}   <= sum_d;
            res_id_q                <= win;
        end else if (state_q == HOLD && res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

endmodule
